// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    localparam int XLEN          = 32;
    localparam int DEF_MEM_WORDS = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs little-endian bytes into a 32-bit word and keeps a running XOR.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_clear,
    input  logic            i_strobe,
    input  logic [7:0]      i_byte,
    output logic [XLEN-1:0] o_word,
    output logic [1:0]      o_count,
    output logic [7:0]      o_csum
);

    logic [XLEN-1:0] r_word;
    logic [1:0]      r_cnt;
    logic [7:0]      r_csum;

    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_word <= '0;
            r_cnt  <= '0;
            r_csum <= '0;
        end else if (i_strobe) begin
            r_word[{r_cnt, 3'b000} +: 8] <= i_byte;
            r_cnt  <= r_cnt + 2'd1;
            r_csum <= r_csum ^ i_byte;
        end
    end

    assign o_word  = r_word;
    assign o_count = r_cnt;
    assign o_csum  = r_csum;

endmodule

// File: rtl/imem_loader.sv
// Streams a counted, checksummed program into instruction memory.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_WORDS = DEF_MEM_WORDS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    output logic [XLEN-1:0] imem_write_address,
    output logic [XLEN-1:0] imem_write_data,
    output logic            imem_write_enable,
    output logic            core_hold,
    output logic            busy,
    output logic            done,
    output logic            error
);

    state_t          r_state;
    logic [7:0]      r_n;
    logic [7:0]      r_widx;
    logic            r_we;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_hold;

    logic            w_accept;
    logic            w_rest;
    logic            w_clear;
    logic            w_strobe;
    logic [XLEN-1:0] w_word;
    logic [1:0]      w_cnt;
    logic [7:0]      w_csum;

    assign w_accept = in_valid && in_ready;
    assign w_rest   = (r_state == S_IDLE) ||
                      (r_state == S_DONE) ||
                      (r_state == S_ERR);
    assign w_clear  = w_rest && start;
    assign w_strobe = (r_state == S_DATA) && w_accept;

    word_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_clear),
        .i_strobe (w_strobe),
        .i_byte   (in_data),
        .o_word   (w_word),
        .o_count  (w_cnt),
        .o_csum   (w_csum)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_widx  <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_hold  <= '0;
        end else begin
            r_we <= 1'b0;
            unique case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_state <= S_COUNT;
                        r_widx  <= '0;
                    end
                end
                S_COUNT: begin
                    if (w_accept) begin
                        if (in_data == 8'd0 ||
                            int'(in_data) > MEM_WORDS) begin
                            r_state <= S_ERR;
                        end else begin
                            r_n     <= in_data;
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept && w_cnt == 2'd3) begin
                        r_state <= S_WRITE;
                        r_we    <= 1'b1;
                        r_addr  <= {{(XLEN-10){1'b0}}, r_widx, 2'b00};
                    end
                end
                S_WRITE: begin
                    // Keep the written word visible once lanes start refilling
                    r_hold <= w_word;
                    if (r_widx == r_n - 8'd1) begin
                        r_state <= S_CSUM;
                    end else begin
                        r_widx  <= r_widx + 8'd1;
                        r_state <= S_DATA;
                    end
                end
                S_CSUM: begin
                    if (w_accept) begin
                        r_state <= (in_data == w_csum) ? S_DONE : S_ERR;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_write_enable  = r_we;
    assign imem_write_address = r_addr;
    assign imem_write_data    = (r_state == S_WRITE) ? w_word : r_hold;

    assign in_ready  = (r_state == S_COUNT) ||
                       (r_state == S_DATA)  ||
                       (r_state == S_CSUM);
    assign busy      = in_ready || (r_state == S_WRITE);
    assign core_hold = busy || (r_state == S_ERR);
    assign done      = (r_state == S_DONE);
    assign error     = (r_state == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [31:0] imem_write_address;
    logic [31:0] imem_write_data;
    logic        imem_write_enable;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        error;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int wr_mark;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;
    logic [31:0] wtmp;

    always #5 clk = ~clk;

    imem_loader #(.MEM_WORDS(64)) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .in_valid           (in_valid),
        .in_data            (in_data),
        .in_ready           (in_ready),
        .imem_write_address (imem_write_address),
        .imem_write_data    (imem_write_data),
        .imem_write_enable  (imem_write_enable),
        .core_hold          (core_hold),
        .busy               (busy),
        .done               (done),
        .error              (error)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_write_enable) begin
            wr_cnt++;
            chk("wr_in_ready", 32'(in_ready), 32'd0);
            chk("wr_busy", 32'(busy), 32'd1);
            chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", imem_write_address, mon_e[63:32]);
                chk("wr_data", imem_write_data, mon_e[31:0]);
            end
        end
    end

    function automatic logic [31:0] gen(input int i);
        logic [7:0] k;
        k = 8'(i);
        if (i == 0) return 32'h0000_0013;
        if (i == 1) return 32'h0010_0093;
        return {k, k ^ 8'hA5, 8'h3C, k + 8'd1};
    endfunction

    task automatic send(input logic [7:0] b, input bit rnd);
        int t;
        bit acc;
        t = 0;
        acc = 1'b0;
        while (!acc && t < 400) begin
            @(negedge clk);
            start = 1'b0;
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data = (in_valid && !in_ready) ? 8'($urandom) : b;
            acc = in_valid && in_ready;
            @(posedge clk);
            t++;
        end
        chk("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic load(input int n, input bit rnd, input int csum_ovr,
                        input bit pulse);
        logic [7:0] cs;
        logic [31:0] w;
        cs = 8'h00;
        do_start();
        send(8'(n), rnd);
        for (int i = 0; i < n; i++) begin
            w = gen(i);
            exp_q.push_back({32'(i * 4), w});
            for (int b = 0; b < 4; b++) begin
                if (pulse && i == 0 && b == 2) begin
                    @(negedge clk);
                    start = 1'b1;
                    in_valid = 1'b0;
                    @(posedge clk);
                end
                send(w[8*b +: 8], rnd);
                cs = cs ^ w[8*b +: 8];
            end
        end
        send((csum_ovr < 0) ? cs : 8'(csum_ovr), rnd);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic finish_chk(input string tag, input bit e_done,
                              input bit e_err, input bit e_hold);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'(e_done));
        chk({tag, "_error"}, 32'(error), 32'(e_err));
        chk({tag, "_hold"}, 32'(core_hold), 32'(e_hold));
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_qempty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_addr"}, imem_write_address, 32'd0);
        chk({tag, "_data"}, imem_write_data, 32'd0);
        chk({tag, "_we"}, 32'(imem_write_enable), 32'd0);
        chk({tag, "_hold"}, 32'(core_hold), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    task automatic bad_count(input logic [7:0] c, input string tag);
        int m;
        m = wr_cnt;
        do_start();
        send(c, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        finish_chk(tag, 1'b0, 1'b1, 1'b1);
        chk({tag, "_nowrite"}, 32'(wr_cnt - m), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk_zero("reset");

        wr_mark = wr_cnt;
        load(2, 1'b0, -1, 1'b0);
        finish_chk("good", 1'b1, 1'b0, 1'b0);
        chk("good_wrcnt", 32'(wr_cnt - wr_mark), 32'd2);

        wr_mark = wr_cnt;
        load(2, 1'b0, 8'h00, 1'b0);
        finish_chk("badsum", 1'b0, 1'b1, 1'b1);
        chk("badsum_wrcnt", 32'(wr_cnt - wr_mark), 32'd2);

        bad_count(8'h00, "cnt00");
        bad_count(8'h41, "cnt41");

        load(2, 1'b1, -1, 1'b0);
        finish_chk("rand", 1'b1, 1'b0, 1'b0);

        load(2, 1'b0, -1, 1'b1);
        finish_chk("pulse", 1'b1, 1'b0, 1'b0);

        wr_mark = wr_cnt;
        do_start();
        send(8'h02, 1'b0);
        wtmp = gen(0);
        exp_q.push_back({32'd0, wtmp});
        for (int b = 0; b < 4; b++) send(wtmp[8*b +: 8], 1'b0);
        wtmp = gen(1);
        send(wtmp[7:0], 1'b0);
        #1;
        reset = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk_zero("abort");
        chk("abort_wrcnt", 32'(wr_cnt - wr_mark), 32'd1);
        chk("abort_qempty", 32'(exp_q.size()), 32'd0);
        load(2, 1'b1, -1, 1'b0);
        finish_chk("reload", 1'b1, 1'b0, 1'b0);

        wr_mark = wr_cnt;
        load(64, 1'b1, -1, 1'b0);
        finish_chk("max", 1'b1, 1'b0, 1'b0);
        chk("max_wrcnt", 32'(wr_cnt - wr_mark), 32'd64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
